alu_unit: RTL and testbench

- Registered, single-cycle-latency integer ALU: two WIDTH-bit operands, 4-bit opcode.
- Produces a WIDTH-bit result plus zero and carry flags.
- Sits in a datapath execute stage; operands and opcode are sampled every enabled clock edge and outputs are held in registers.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_unit_comb.sv | 82 ++++++++
 rtl/alu_unit.sv | 71 +++++++
 tb/tb_alu_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and default width for the execute-stage ALU.
package alu_pkg;

   localparam int unsigned ALU_WIDTH  = 8;
   localparam int unsigned OP_WIDTH   = 4;

   typedef enum logic [OP_WIDTH-1:0] {
      OP_ADD   = 4'b0000,
      OP_SUB   = 4'b0001,
      OP_AND   = 4'b0010,
      OP_OR    = 4'b0011,
      OP_XOR   = 4'b0100,
      OP_NOT   = 4'b0101,
      OP_SHL   = 4'b0110,
      OP_SHR   = 4'b0111,
      OP_ASR   = 4'b1000,
      OP_ROL   = 4'b1001,
      OP_ROR   = 4'b1010,
      OP_INC   = 4'b1011,
      OP_DEC   = 4'b1100,
      OP_SLTU  = 4'b1101,
      OP_PASSA = 4'b1110,
      OP_PASSB = 4'b1111
   } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_unit_comb.sv
// Combinational ALU datapath: opcode decode, result selection and flag generation.
module alu_unit_comb
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   input  logic [OP_WIDTH-1:0] opcode,
   output logic [WIDTH-1:0]    result_c,
   output logic                zero_c,
   output logic                carry_c
);

   alu_op_e      op;
   logic [WIDTH:0] add_full;
   logic [WIDTH:0] sub_full;
   logic           a_lt_b;

   assign op = alu_op_e'(opcode);

   // Extended add/sub so the top bit is the carry or borrow.
   assign add_full = {1'b0, a} + {1'b0, b};
   assign sub_full = {1'b0, a} - {1'b0, b};
   assign a_lt_b   = (a < b);

   always_comb begin
      result_c = '0;
      carry_c  = 1'b0;
      case (op)
         OP_ADD: begin
            result_c = add_full[WIDTH-1:0];
            carry_c  = add_full[WIDTH];
         end
         OP_SUB: begin
            result_c = sub_full[WIDTH-1:0];
            carry_c  = sub_full[WIDTH];
         end
         OP_AND:   result_c = a & b;
         OP_OR:    result_c = a | b;
         OP_XOR:   result_c = a ^ b;
         OP_NOT:   result_c = ~a;
         OP_SHL: begin
            result_c = {a[WIDTH-2:0], 1'b0};
            carry_c  = a[WIDTH-1];
         end
         OP_SHR: begin
            result_c = {1'b0, a[WIDTH-1:1]};
            carry_c  = a[0];
         end
         OP_ASR: begin
            result_c = {a[WIDTH-1], a[WIDTH-1:1]};
            carry_c  = a[0];
         end
         OP_ROL: begin
            result_c = {a[WIDTH-2:0], a[WIDTH-1]};
            carry_c  = a[WIDTH-1];
         end
         OP_ROR: begin
            result_c = {a[0], a[WIDTH-1:1]};
            carry_c  = a[0];
         end
         OP_INC: begin
            result_c = a + WIDTH'(1);
            carry_c  = &a;
         end
         OP_DEC: begin
            result_c = a - WIDTH'(1);
            carry_c  = ~|a;
         end
         OP_SLTU: begin
            result_c = {{(WIDTH-1){1'b0}}, a_lt_b};
            carry_c  = a_lt_b;
         end
         OP_PASSA: result_c = a;
         OP_PASSB: result_c = b;
      endcase
   end

   assign zero_c = (result_c == '0);

endmodule : alu_unit_comb

// File: rtl/alu_unit.sv
// Registered single-cycle ALU: enable-gated output registers around alu_unit_comb.
module alu_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   input  logic [OP_WIDTH-1:0] opcode,
   output logic [WIDTH-1:0]    result,
   output logic                zero,
   output logic                carry,
   output logic                valid
);

   logic [WIDTH-1:0] alu_result_c;
   logic             alu_zero_c;
   logic             alu_carry_c;

   logic [WIDTH-1:0] result_d, result_q;
   logic             zero_d,   zero_q;
   logic             carry_d,  carry_q;
   logic             valid_d,  valid_q;

   alu_unit_comb #(
      .WIDTH (WIDTH)
   ) u_comb (
      .a        (a),
      .b        (b),
      .opcode   (opcode),
      .result_c (alu_result_c),
      .zero_c   (alu_zero_c),
      .carry_c  (alu_carry_c)
   );

   // Outputs hold while disabled; valid tracks whether this edge was enabled.
   always_comb begin
      result_d = result_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      valid_d  = en;
      if (en) begin
         result_d = alu_result_c;
         zero_d   = alu_zero_c;
         carry_d  = alu_carry_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         zero_q   <= 1'b1;
         carry_q  <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         valid_q  <= valid_d;
      end
   end

   assign result = result_q;
   assign zero   = zero_q;
   assign carry  = carry_q;
   assign valid  = valid_q;

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit with hand-computed expected values.
module tb_alu_unit;
   import alu_pkg::*;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             valid;

   int checks = 0;
   int errors = 0;

   alu_unit #(
      .WIDTH (WIDTH)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .a      (a),
      .b      (b),
      .opcode (opcode),
      .result (result),
      .zero   (zero),
      .carry  (carry),
      .valid  (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] er, input logic ez,
                          input logic ec, input logic ev);
      chk({tag, ".result"}, 32'(result), 32'(er));
      chk({tag, ".zero"},   32'(zero),   32'(ez));
      chk({tag, ".carry"},  32'(carry),  32'(ec));
      chk({tag, ".valid"},  32'(valid),  32'(ev));
   endtask

   // Apply one enabled operation and sample just after the capturing edge.
   task automatic run_op(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb);
      @(negedge clk);
      en     = 1'b1;
      opcode = op;
      a      = va;
      b      = vb;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n  = 1'b0;
      en     = 1'b0;
      a      = '0;
      b      = '0;
      opcode = '0;

      #12;
      chk_all("reset", 8'h00, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(OP_ADD, 8'h02, 8'h01);
      chk_all("add_2_1", 8'h03, 1'b0, 1'b0, 1'b1);
      run_op(OP_ADD, 8'hFF, 8'h01);
      chk_all("add_ff_1", 8'h00, 1'b1, 1'b1, 1'b1);
      run_op(OP_SUB, 8'h01, 8'h02);
      chk_all("sub_1_2", 8'hFF, 1'b0, 1'b1, 1'b1);
      run_op(OP_SUB, 8'h05, 8'h05);
      chk_all("sub_5_5", 8'h00, 1'b1, 1'b0, 1'b1);

      run_op(OP_SHL, 8'h81, 8'h00);
      chk_all("shl_81", 8'h02, 1'b0, 1'b1, 1'b1);
      run_op(OP_SHR, 8'h81, 8'h00);
      chk_all("shr_81", 8'h40, 1'b0, 1'b1, 1'b1);
      run_op(OP_ASR, 8'h81, 8'h00);
      chk_all("asr_81", 8'hC0, 1'b0, 1'b1, 1'b1);
      run_op(OP_ROL, 8'h81, 8'h00);
      chk_all("rol_81", 8'h03, 1'b0, 1'b1, 1'b1);
      run_op(OP_ROR, 8'h81, 8'h00);
      chk_all("ror_81", 8'hC0, 1'b0, 1'b1, 1'b1);
      run_op(OP_ASR, 8'h42, 8'h00);
      chk_all("asr_42", 8'h21, 1'b0, 1'b0, 1'b1);

      run_op(OP_AND, 8'hF0, 8'h0F);
      chk_all("and_f0_0f", 8'h00, 1'b1, 1'b0, 1'b1);
      run_op(OP_OR, 8'hF0, 8'h0F);
      chk_all("or_f0_0f", 8'hFF, 1'b0, 1'b0, 1'b1);
      run_op(OP_XOR, 8'hF0, 8'h0F);
      chk_all("xor_f0_0f", 8'hFF, 1'b0, 1'b0, 1'b1);
      run_op(OP_NOT, 8'hF0, 8'h0F);
      chk_all("not_f0", 8'h0F, 1'b0, 1'b0, 1'b1);
      run_op(OP_SLTU, 8'hF0, 8'h0F);
      chk_all("sltu_f0_0f", 8'h00, 1'b1, 1'b0, 1'b1);
      run_op(OP_SLTU, 8'h0F, 8'hF0);
      chk_all("sltu_0f_f0", 8'h01, 1'b0, 1'b1, 1'b1);

      run_op(OP_INC, 8'h7F, 8'h00);
      chk_all("inc_7f", 8'h80, 1'b0, 1'b0, 1'b1);
      run_op(OP_DEC, 8'h00, 8'h00);
      chk_all("dec_00", 8'hFF, 1'b0, 1'b1, 1'b1);
      run_op(OP_DEC, 8'h01, 8'h00);
      chk_all("dec_01", 8'h00, 1'b1, 1'b0, 1'b1);
      run_op(OP_PASSA, 8'h5A, 8'hA5);
      chk_all("passa", 8'h5A, 1'b0, 1'b0, 1'b1);
      run_op(OP_PASSB, 8'h5A, 8'hA5);
      chk_all("passb", 8'hA5, 1'b0, 1'b0, 1'b1);

      // Hold: disabled edges keep the last result while inputs change.
      run_op(OP_ADD, 8'h02, 8'h01);
      chk_all("hold_setup", 8'h03, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         en     = 1'b0;
         a      = 8'hFF - 8'(i);
         b      = 8'h10 + 8'(i);
         opcode = OP_SUB;
         @(posedge clk);
         #1;
         chk_all($sformatf("hold_%0d", i), 8'h03, 1'b0, 1'b0, 1'b0);
      end

      // Async reset between edges clears outputs immediately.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 8'h00, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(OP_INC, 8'hFF, 8'h00);
      chk_all("inc_ff", 8'h00, 1'b1, 1'b1, 1'b1);

      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #1;
      chk_all("idle_after_inc", 8'h00, 1'b1, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_alu_unit
